// File: rtl/seg_display.sv
// seg_display: 8-digit multiplexed 7-segment driver for a clock / stopwatch readout.
// Optional macro LEAD_ZERO_BLANK_EN blanks the hours tens digit when it is zero.
module seg_display #(
    parameter int SCAN_DIV  = 5,
    parameter int BLINK_DIV = 2500
) (
    input  logic       Clock_5K,
    input  logic       Reset,
    input  logic       Control,
    input  logic [3:0] Hours,
    input  logic [5:0] Mins,
    input  logic [5:0] Secs,
    input  logic [9:0] MSecs,
    input  logic       AM_PM,
    input  logic       Alarm,
    input  logic       SW_State,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic [7:0] Digit,
    output logic       Busy
);

    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_P     = 7'b0001100;

    // A frame must be long enough to hold one full conversion plus commit.
    if (SCAN_DIV * 8 < 28) begin : g_bad_scan_div
        $error("seg_display: SCAN_DIV*8 must be at least 28");
    end

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = GLYPH_BLANK;
        endcase
    endfunction

    function automatic logic [15:0] add3(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [25:0]         sr_q, sr_d;
    logic                ctrl_sh_q, ctrl_sh_d;
    logic                ap_sh_q, ap_sh_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [15:0]         acc_q, acc_d;
    logic [7:0]          h_bcd_q, h_bcd_d;
    logic [7:0]          m_bcd_q, m_bcd_d;
    logic [7:0]          s_bcd_q, s_bcd_d;
    logic [7:0]          ms_bcd_q, ms_bcd_d;
    logic [7:0][6:0]     disp_q, disp_d;
    logic                disp_sw_q, disp_sw_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [7:0]          digit_q, digit_d;

    logic                frame_start, snap, dark;
    logic [15:0]         acc_add, acc_shift;

    always_comb begin
        state_d       = state_q;
        scan_cnt_d    = scan_cnt_q;
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        sr_d          = sr_q;
        ctrl_sh_d     = ctrl_sh_q;
        ap_sh_d       = ap_sh_q;
        bit_cnt_d     = bit_cnt_q;
        acc_d         = acc_q;
        h_bcd_d       = h_bcd_q;
        m_bcd_d       = m_bcd_q;
        s_bcd_d       = s_bcd_q;
        ms_bcd_d      = ms_bcd_q;
        disp_d        = disp_q;
        disp_sw_d     = disp_sw_q;
        acc_add       = add3(acc_q);
        acc_shift     = {acc_add[14:0], sr_q[25]};

        frame_start = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) && (idx_q == 3'd0);
        snap        = SW_State || frame_start;

        if (SW_State) begin
            scan_cnt_d = '0;
            idx_d      = 3'd7;
        end else if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = idx_q - 3'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end

        if (!Alarm) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = !blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end

        case (state_q)
            CONV: begin
                // Field boundaries in the {Hours,Mins,Secs,MSecs} stream: bits 3, 9, 15, 25.
                sr_d      = {sr_q[24:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 5'd1;
                acc_d     = acc_shift;
                case (bit_cnt_q)
                    5'd3:  begin h_bcd_d = acc_shift[7:0]; acc_d = '0; end
                    5'd9:  begin m_bcd_d = acc_shift[7:0]; acc_d = '0; end
                    5'd15: begin s_bcd_d = acc_shift[7:0]; acc_d = '0; end
                    5'd25: begin ms_bcd_d = acc_shift[11:4]; acc_d = '0; state_d = COMMIT; end
                    default: ;
                endcase
            end
            COMMIT: begin
`ifdef LEAD_ZERO_BLANK_EN
                disp_d[7] = (h_bcd_q[7:4] == 4'd0) ? GLYPH_BLANK : glyph(h_bcd_q[7:4]);
`else
                disp_d[7] = glyph(h_bcd_q[7:4]);
`endif
                disp_d[6] = glyph(h_bcd_q[3:0]);
                disp_d[5] = glyph(m_bcd_q[7:4]);
                disp_d[4] = glyph(m_bcd_q[3:0]);
                disp_d[3] = glyph(s_bcd_q[7:4]);
                disp_d[2] = glyph(s_bcd_q[3:0]);
                if (ctrl_sh_q) begin
                    disp_d[1] = GLYPH_BLANK;
                    disp_d[0] = ap_sh_q ? GLYPH_P : GLYPH_A;
                end else begin
                    disp_d[1] = glyph(ms_bcd_q[7:4]);
                    disp_d[0] = glyph(ms_bcd_q[3:0]);
                end
                disp_sw_d = !ctrl_sh_q;
                state_d   = IDLE;
            end
            default: ;
        endcase

        // A new snapshot restarts conversion and cancels any pending commit.
        if (snap) begin
            state_d   = CONV;
            bit_cnt_d = '0;
            acc_d     = '0;
            sr_d      = {Hours, Mins, Secs, MSecs};
            ctrl_sh_d = Control;
            ap_sh_d   = AM_PM;
            disp_d    = disp_q;
            disp_sw_d = disp_sw_q;
        end

        dark    = Alarm && blink_phase_q;
        digit_d = dark ? 8'hFF : ~(8'd1 << idx_q);
        seg_d   = dark ? GLYPH_BLANK : disp_q[idx_q];
        dp_d    = dark ? 1'b1
                       : !((idx_q == 3'd6) || (idx_q == 3'd4) || ((idx_q == 3'd2) && disp_sw_q));
    end

    always_ff @(posedge Clock_5K) begin
        if (Reset) begin
            state_q       <= IDLE;
            scan_cnt_q    <= '0;
            idx_q         <= 3'd7;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            sr_q          <= '0;
            ctrl_sh_q     <= 1'b0;
            ap_sh_q       <= 1'b0;
            bit_cnt_q     <= '0;
            acc_q         <= '0;
            h_bcd_q       <= '0;
            m_bcd_q       <= '0;
            s_bcd_q       <= '0;
            ms_bcd_q      <= '0;
            disp_q        <= {8{GLYPH_BLANK}};
            disp_sw_q     <= 1'b0;
            seg_q         <= GLYPH_BLANK;
            dp_q          <= 1'b1;
            digit_q       <= 8'hFF;
        end else begin
            state_q       <= state_d;
            scan_cnt_q    <= scan_cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            sr_q          <= sr_d;
            ctrl_sh_q     <= ctrl_sh_d;
            ap_sh_q       <= ap_sh_d;
            bit_cnt_q     <= bit_cnt_d;
            acc_q         <= acc_d;
            h_bcd_q       <= h_bcd_d;
            m_bcd_q       <= m_bcd_d;
            s_bcd_q       <= s_bcd_d;
            ms_bcd_q      <= ms_bcd_d;
            disp_q        <= disp_d;
            disp_sw_q     <= disp_sw_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            digit_q       <= digit_d;
        end
    end

    assign Seg   = seg_q;
    assign Dp    = dp_q;
    assign Digit = digit_q;
    assign Busy  = (state_q != IDLE);

endmodule

// File: doc/seg_display.md
SEG_DISPLAY -- requirements
Module: seg_display

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named Clock_5K and Reset.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- SCAN_DIV, 5: Clock_5K cycles per digit slot.
- BLINK_DIV, 2500: Clock_5K cycles per alarm-blink half-period.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- Clock_5K  in  1  system clock.
- Reset  in  1  synchronous active-high reset.
- Control  in  1  1 = clock mode, 0 = stopwatch mode.
- Hours  in  4  binary hours.
- Mins  in  6  binary minutes.
- Secs  in  6  binary seconds.
- MSecs  in  10  binary milliseconds.
- AM_PM  in  1  1 = PM.
- Alarm  in  1  alarm active.
- SW_State  in  1  one-cycle mode-change pulse.
- Seg  out  7  segments, active-low, bit0 = a ... bit6 = g.
- Dp  out  1  decimal point, active-low.
- Digit  out  8  anode select, one-hot, active-low; bit7 = leftmost digit.
- Busy  out  1  conversion in progress.

Function
REQ-004 A scan counter SHALL count 0..SCAN_DIV-1; on wrap, the digit index SHALL decrement 7→0, then wrap to 7; Digit SHALL be low only at the bit equal to the index.
REQ-005 Frame start SHALL be the cycle in which the index wraps 0→7; at frame start the block SHALL snapshot Control, Hours, Mins, Secs, MSecs and AM_PM into shadow registers.
REQ-006 The FSM SHALL have three states: IDLE, CONV and COMMIT.
- IDLE→CONV on snapshot.
- CONV SHALL shift-add-3 convert the 26 snapshot bits (Hours, Mins, Secs, MSecs), one bit per cycle, for exactly 26 cycles, then go to COMMIT.
- COMMIT SHALL load all display digit registers in one cycle, then return to IDLE.
REQ-007 Busy SHALL be 1 exactly in CONV and COMMIT (27 cycles); snapshot-to-display-register latency SHALL be 28 cycles.
REQ-008 SCAN_DIV*8 SHALL be at least 28; a smaller value SHALL be a parameter error, reported by simulation $error at time 0.
REQ-009 Clock mode digit map, digits 7..0, SHALL be H1 H0 M1 M0 S1 S0, blank, then 'A' (AM_PM=0) or 'P' (AM_PM=1).
REQ-010 Stopwatch mode digit map, digits 7..0, SHALL be H1 H0 M1 M0 S1 S0 ms2 ms1, where ms2 is the hundreds digit of MSecs and ms1 its tens digit; the ms0 digit SHALL be discarded.
REQ-011 Out-of-range values (e.g. Mins = 63, Hours = 15) SHALL be displayed numerically, with no clamping.
REQ-012 Glyph codes SHALL be:
- '0' = 7'b1000000.
- 'A' = 7'b0001000.
- 'P' = 7'b0001100.
- blank = 7'b1111111.
- Digits 1-9 use the standard active-low encoding.
REQ-013 Dp SHALL be 0 on digits 6 and 4 in both modes, and on digit 2 in stopwatch mode only; Dp SHALL be 1 on all other digits.
REQ-014 Seg, Dp and Digit SHALL be registered, changing one cycle after the index update.
REQ-015 When Alarm=1, a blink counter SHALL toggle the blink phase every BLINK_DIV cycles; in the off phase, Digit SHALL be 8'hFF and Seg SHALL be blank.
REQ-016 When Alarm=0, the blink counter and phase SHALL be held at 0, so the display is on.
REQ-017 When SW_State=1, in the next cycle the scan counter SHALL be set to 0, the index set to 7, any conversion aborted, and a new snapshot taken.
- This SHALL apply in any FSM state.
- Display registers SHALL keep their old values until the next COMMIT.
REQ-018 SW_State coinciding with a natural frame start SHALL produce exactly one snapshot.

Reset
REQ-019 When Reset=1 at a clock edge, the block SHALL set:
- Seg=7'h7F, Dp=1, Digit=8'hFF, Busy=0.
- FSM=IDLE, index=7.
- Scan counter, blink counter and blink phase = 0.
- All display digit registers = blank.
REQ-020 Reset asserted mid-conversion SHALL abort it without a COMMIT; the first snapshot SHALL occur at the first frame start after Reset deasserts.

Configuration
REQ-021 With LEAD_ZERO_BLANK_EN defined, digit 7 (H1) SHALL show blank when its value is 0.
REQ-022 Without LEAD_ZERO_BLANK_EN, digit 7 (H1) SHALL show '0' when its value is 0.

Verification
REQ-023 Reset held for 3 cycles -> Seg=7'h7F, Dp=1, Digit=8'hFF and Busy=0 on every cycle, including the cycle after release.
REQ-024 Control=1, Hours=9, Mins=5, Secs=42, AM_PM=1, second frame -> digits show [blank or '0'],9,0,5,4,2,blank,'P'; Dp=0 at digits 6 and 4 only.
REQ-025 Control=0, Hours=0, Mins=59, Secs=7, MSecs=999 -> digits show [blank or '0'],0,5,9,0,7,9,9; Dp=0 at digits 6, 4 and 2.
REQ-026 SW_State pulsed 10 cycles into CONV -> Busy stays 1; index=7 next cycle; COMMIT occurs 28 cycles after the pulse, with no commit of the aborted data.
REQ-027 Alarm=1 for 6000 cycles -> Digit=8'hFF during cycles 2500-4999 of the alarm; Alarm=0 -> scanning resumes immediately.
REQ-028 Mins=63, Hours=15 -> digits show 1,5,6,3, with H1 never blanked because it is nonzero.
